// File: rtl/mvm_stream_engine.sv
// Column-streamed unsigned matrix-vector MAC engine, y = A*b, one MAC lane per row.
// Build option MVM_SATURATE_EN: saturating accumulate with sticky ovf; otherwise wrap and ovf=0.
//
// state  | meaning
// IDLE   | waiting for start, accumulators hold last cleared/reset value
// RUN    | accepting operand beats, in_ready=1
// DONE   | results frozen and valid, waiting for next start
module mvm_stream_engine #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_vec,
  input  logic [ROWS*DATA_W-1:0] in_col,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf,
  input  logic [RIDX_W-1:0]      rd_idx,
  output logic [ACC_W-1:0]       rd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // one spare bit so the count can reach COLS without wrapping
  localparam int CNT_W = $clog2(COLS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COLS - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q   [ROWS];
  logic [ACC_W-1:0]    acc_d   [ROWS];
  logic [ACC_W-1:0]    acc_sum [ROWS];
  logic [2*DATA_W-1:0] prod    [ROWS];
  logic [ACC_W-1:0]    rd_data_q, rd_data_d;
  logic [RIDX_W:0]     rd_idx_ext;
  logic                accept;
  logic                clear;

  assign accept = in_valid && (state_q == S_RUN);
  assign clear  = start && (state_q != S_RUN);

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      prod[i] = in_col[i*DATA_W +: DATA_W] * in_vec;
    end
  end

`ifdef MVM_SATURATE_EN
  logic [ACC_W:0] sum_wide [ROWS];
  logic           clamp;
  logic           ovf_q, ovf_d;

  always_comb begin
    clamp = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      sum_wide[i] = (ACC_W+1)'(acc_q[i]) + (ACC_W+1)'(prod[i]);
      if (sum_wide[i][ACC_W]) begin
        acc_sum[i] = '1;
        clamp      = 1'b1;
      end else begin
        acc_sum[i] = sum_wide[i][ACC_W-1:0];
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (accept && clamp) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      acc_sum[i] = acc_q[i] + ACC_W'(prod[i]);
    end
  end

  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          for (int i = 0; i < ROWS; i++) begin
            acc_d[i] = '0;
          end
        end
      end
      S_RUN: begin
        if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // out-of-range row indices read as zero when ROWS is not a power of two
  assign rd_idx_ext = {1'b0, rd_idx};

  always_comb begin
    rd_data_d = '0;
    if (rd_idx_ext < (RIDX_W+1)'(ROWS)) begin
      rd_data_d = acc_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < ROWS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      acc_q     <= acc_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign in_ready = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_mvm_stream_engine.sv
// Self-checking bench for mvm_stream_engine: table vectors, hand-written corner
// sequences and randomized runs compared against an arithmetic reference model.
module tb_mvm_stream_engine;
  localparam int ROWS = 8, COLS = 8, DW = 8, AW = 24;
  localparam int S_ROWS = 2, S_COLS = 2, S_AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, in_valid, in_ready, busy, done, ovf;
  logic [DW-1:0]      in_vec;
  logic [ROWS*DW-1:0] in_col;
  logic [2:0]         rd_idx;
  logic [AW-1:0]      rd_data;

  logic s_start, s_in_valid, s_in_ready, s_busy, s_done, s_ovf;
  logic [DW-1:0]        s_in_vec;
  logic [S_ROWS*DW-1:0] s_in_col;
  logic [0:0]           s_rd_idx;
  logic [S_AW-1:0]      s_rd_data;

  mvm_stream_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .in_col(in_col), .busy(busy), .done(done), .ovf(ovf),
    .rd_idx(rd_idx), .rd_data(rd_data));

  mvm_stream_engine #(.ROWS(S_ROWS), .COLS(S_COLS), .DATA_W(DW), .ACC_W(S_AW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_vec(s_in_vec), .in_col(s_in_col), .busy(s_busy), .done(s_done), .ovf(s_ovf),
    .rd_idx(s_rd_idx), .rd_data(s_rd_data));

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] A [ROWS][COLS];
  logic [DW-1:0] bv [COLS];

  typedef struct {
    string    name;
    int       kind;
    bit       toggle;
    logic [AW-1:0] y0;
    logic [AW-1:0] y7;
    int       lat;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: A=i+1, b=j+1; kind 1: all 0xFF; kind 2: random
  task automatic fill(input int kind);
    for (int j = 0; j < COLS; j++) begin
      bv[j] = (kind == 0) ? DW'(j + 1) : (kind == 1) ? 8'hFF : DW'($urandom);
      for (int i = 0; i < ROWS; i++)
        A[i][j] = (kind == 0) ? DW'(i + 1) : (kind == 1) ? 8'hFF : DW'($urandom);
    end
  endtask

  function automatic logic [ROWS*DW-1:0] pack(input int k);
    logic [ROWS*DW-1:0] v;
    for (int i = 0; i < ROWS; i++) v[i*DW +: DW] = A[i][k];
    return v;
  endfunction

  function automatic longint unsigned model_y(input int i, input int ncols, input int accw);
    longint unsigned s, mx;
    s  = 0;
    mx = (64'd1 << accw) - 1;
    for (int j = 0; j < ncols; j++) begin
      s = s + longint'(A[i][j]) * longint'(bv[j]);
`ifdef MVM_SATURATE_EN
      if (s > mx) s = mx;
`else
      s = s & mx;
`endif
    end
    return s;
  endfunction

  function automatic bit model_ovf(input int nrows, input int ncols, input int accw);
    bit o;
    o = 1'b0;
`ifdef MVM_SATURATE_EN
    for (int i = 0; i < nrows; i++) begin
      longint unsigned s;
      s = 0;
      for (int j = 0; j < ncols; j++) s = s + longint'(A[i][j]) * longint'(bv[j]);
      if (s > ((64'd1 << accw) - 1)) o = 1'b1;
    end
`endif
    return o;
  endfunction

  // Runs one pass on the main DUT from IDLE/DONE; lat counts edges from the start edge
  // (inclusive) to the edge after which done is seen, -1 on timeout.
  task automatic run(input bit toggle, input bit rnd, input int start_at, output int lat);
    int k, edges, hs_err;
    bit ph, v;
    start = 1'b1; in_valid = 1'b1; in_vec = bv[0]; in_col = pack(0);
    tick();
    start = 1'b0; edges = 1; k = 0; ph = 1'b0; lat = -1; hs_err = 0;
    for (int c = 0; c < 300; c++) begin
      if (rnd) v = ($urandom_range(0, 2) != 0);
      else if (toggle) begin v = !ph; ph = !ph; end
      else v = 1'b1;
      if (k >= COLS) v = 1'b0;
      in_valid = v;
      if (k < COLS) begin in_vec = bv[k]; in_col = pack(k); end
      start = (start_at >= 0) && (k == start_at) && v;
      tick();
      start = 1'b0;
      edges++;
      if (v) k++;
      if (in_ready !== busy || busy === done) hs_err++;
      if (done === 1'b1) begin lat = edges; break; end
    end
    in_valid = 1'b0;
    chk("run_handshake_flags", 64'(hs_err), 64'd0);
    chk("run_completed", 64'(lat >= 0), 64'd1);
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < ROWS; i++) begin
      rd_idx = 3'(i);
      tick();
      chk($sformatf("%s_y%0d", tag, i), 64'(rd_data), model_y(i, COLS, AW));
    end
    chk({tag, "_ovf"}, 64'(ovf), 64'(model_ovf(ROWS, COLS, AW)));
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_vec = '0; in_col = '0; rd_idx = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_vec = '0; s_in_col = '0; s_rd_idx = '0;
    repeat (3) tick();
    chk("reset_outputs", {busy, done, in_ready, ovf, rd_data}, '0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{"ramp",    0, 1'b0, 24'h24,    24'h120,    9};
    vecs[1] = '{"all_ff",  1, 1'b0, 24'h7F008, 24'h7F008,  9};
    vecs[2] = '{"toggled", 0, 1'b1, 24'h24,    24'h120,   16};
    for (int t = 0; t < 3; t++) begin
      fill(vecs[t].kind);
      run(vecs[t].toggle, 1'b0, -1, lat);
      chk({vecs[t].name, "_latency"}, 64'(lat), 64'(vecs[t].lat));
      rd_idx = 3'd0; tick();
      chk({vecs[t].name, "_y0"}, 64'(rd_data), 64'(vecs[t].y0));
      rd_idx = 3'd7; tick();
      chk({vecs[t].name, "_y7"}, 64'(rd_data), 64'(vecs[t].y7));
      chk({vecs[t].name, "_ovf"}, 64'(ovf), 64'd0);
    end

    // readout latency sweep on ramp data (distinct per row)
    fill(0);
    run(1'b0, 1'b0, -1, lat);
    rd_idx = 3'd0; tick();
    for (int i = 1; i < ROWS; i++) begin
      rd_idx = 3'(i);
      #1;
      chk($sformatf("rd_hold_%0d", i), 64'(rd_data), model_y(i - 1, COLS, AW));
      tick();
      chk($sformatf("rd_update_%0d", i), 64'(rd_data), model_y(i, COLS, AW));
    end

    // start during RUN is ignored; start in DONE clears
    fill(0);
    run(1'b0, 1'b0, 3, lat);
    chk("start_in_run_latency", 64'(lat), 64'd9);
    check_rows("start_in_run");
    start = 1'b1; rd_idx = 3'd7; tick(); start = 1'b0;
    chk("restart_done_low", 64'(done), 64'd0);
    chk("restart_busy_high", 64'(busy), 64'd1);
    tick();
    chk("restart_acc_cleared", 64'(rd_data), 64'd0);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // reset asserted mid-run
    fill(0);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_vec = bv[k]; in_col = pack(k);
      tick();
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrun_reset_outputs", {busy, done, in_ready, ovf, rd_data}, '0);
    tick(); rst_n = 1'b1; tick();
    chk("midrun_reset_idle", {busy, done}, '0);
    run(1'b0, 1'b0, -1, lat);
    chk("after_reset_latency", 64'(lat), 64'd9);
    check_rows("after_reset");

    for (int r = 0; r < 6; r++) begin
      fill(2);
      run(1'b0, 1'b1, -1, lat);
      check_rows($sformatf("random%0d", r));
    end

    // narrow-accumulator instance: overflow behaviour
    fill(1);
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int k = 0; k < S_COLS; k++) begin
      s_in_valid = 1'b1; s_in_vec = bv[k];
      for (int i = 0; i < S_ROWS; i++) s_in_col[i*DW +: DW] = A[i][k];
      tick();
    end
    s_in_valid = 1'b0;
    for (int c = 0; c < 20 && s_done !== 1'b1; c++) tick();
    chk("narrow_done", 64'(s_done), 64'd1);
    for (int i = 0; i < S_ROWS; i++) begin
      s_rd_idx = 1'(i); tick();
`ifdef MVM_SATURATE_EN
      chk($sformatf("narrow_y%0d", i), 64'(s_rd_data), 64'hFFFF);
`else
      chk($sformatf("narrow_y%0d", i), 64'(s_rd_data), 64'hFC02);
`endif
      chk($sformatf("narrow_model_y%0d", i), 64'(s_rd_data), model_y(i, S_COLS, S_AW));
    end
`ifdef MVM_SATURATE_EN
    chk("narrow_ovf", 64'(s_ovf), 64'd1);
`else
    chk("narrow_ovf", 64'(s_ovf), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
